sha256_compressor: RTL and testbench



---
 rtl/sha256_pkg.sv | 52 +++++
 rtl/sha256_compressor_if.sv | 22 ++
 rtl/sha256_round.sv | 29 ++
 rtl/sha256_compressor.sv | 51 +++++
 tb/tb_sha256_compressor.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: word type, initial hash, round constants and
// the bit-mixing functions used by the round and message-schedule logic.
package sha256_pkg;

   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;

   localparam word_t H_INIT [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam word_t K_TABLE [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic word_t big_sigma0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t big_sigma1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t small_sigma0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t small_sigma1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic word_t ch(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic word_t maj(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/sha256_compressor_if.sv
// Control/data bundle between the block controller (master) and the
// compression datapath (slave).
interface sha256_compressor_if;
   import sha256_pkg::*;

   logic  init;
   logic  en;
   word_t hash0, hash1, hash2, hash3, hash4, hash5, hash6, hash7;
   word_t w;
   word_t k;
   word_t A, B, C, D, E, F, G, H;

   modport master (
      output init, en, hash0, hash1, hash2, hash3, hash4, hash5, hash6, hash7, w, k,
      input  A, B, C, D, E, F, G, H
   );

   modport slave (
      input  init, en, hash0, hash1, hash2, hash3, hash4, hash5, hash6, hash7, w, k,
      output A, B, C, D, E, F, G, H
   );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: current a..h plus W[t]/K[t] in,
// next a..h out.
module sha256_round
   import sha256_pkg::*;
(
   input  word_t a, b, c, d, e, f, g, h,
   input  word_t w,
   input  word_t k,
   output word_t a_nxt, b_nxt, c_nxt, d_nxt, e_nxt, f_nxt, g_nxt, h_nxt
);

   word_t t1;
   word_t t2;

   always_comb begin
      t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
      t2 = big_sigma0(a) + maj(a, b, c);
   end

   assign a_nxt = t1 + t2;
   assign b_nxt = a;
   assign c_nxt = b;
   assign d_nxt = c;
   assign e_nxt = d + t1;
   assign f_nxt = e;
   assign g_nxt = f;
   assign h_nxt = g;

endmodule

// File: rtl/sha256_compressor.sv
// SHA-256 working-variable register bank: one round per enabled clock,
// loadable from an intermediate hash; priority rst > init > en > hold.
module sha256_compressor
   import sha256_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic clk,
   input logic rst,
   sha256_compressor_if.slave bus
);

   logic [WIDTH-1:0] st [8];
   word_t            nxt [8];

   sha256_round u_round (
      .a     (st[0]), .b     (st[1]), .c     (st[2]), .d     (st[3]),
      .e     (st[4]), .f     (st[5]), .g     (st[6]), .h     (st[7]),
      .w     (bus.w),
      .k     (bus.k),
      .a_nxt (nxt[0]), .b_nxt (nxt[1]), .c_nxt (nxt[2]), .d_nxt (nxt[3]),
      .e_nxt (nxt[4]), .f_nxt (nxt[5]), .g_nxt (nxt[6]), .h_nxt (nxt[7])
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) st[i] <= '0;
      end else if (bus.init) begin
         st[0] <= bus.hash0;
         st[1] <= bus.hash1;
         st[2] <= bus.hash2;
         st[3] <= bus.hash3;
         st[4] <= bus.hash4;
         st[5] <= bus.hash5;
         st[6] <= bus.hash6;
         st[7] <= bus.hash7;
      end else if (bus.en) begin
         for (int i = 0; i < 8; i++) st[i] <= nxt[i];
      end
   end

   assign bus.A = st[0];
   assign bus.B = st[1];
   assign bus.C = st[2];
   assign bus.D = st[3];
   assign bus.E = st[4];
   assign bus.F = st[5];
   assign bus.G = st[6];
   assign bus.H = st[7];

endmodule

// File: tb/tb_sha256_compressor.sv
// Directed bench for sha256_compressor: "abc" block through all 64 rounds,
// stall/priority corners, checked every cycle against a behavioural model.
module tb_sha256_compressor;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic chk_en;

   logic [31:0] iv [8];
   logic [31:0] kt [64];
   logic [31:0] ws [64];
   logic [31:0] m  [8];

   sha256_compressor_if bus ();

   sha256_compressor #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   function automatic logic [31:0] dut_reg(input int i);
      case (i)
         0: return bus.A;
         1: return bus.B;
         2: return bus.C;
         3: return bus.D;
         4: return bus.E;
         5: return bus.F;
         6: return bus.G;
         default: return bus.H;
      endcase
   endfunction

   // Behavioural reference: spec round equations on an 8-word array.
   always @(posedge clk) begin
      logic [31:0] t1, t2;
      if (rst) begin
         for (int i = 0; i < 8; i++) m[i] = 32'h0;
      end else if (bus.init) begin
         m[0] = bus.hash0; m[1] = bus.hash1; m[2] = bus.hash2; m[3] = bus.hash3;
         m[4] = bus.hash4; m[5] = bus.hash5; m[6] = bus.hash6; m[7] = bus.hash7;
      end else if (bus.en) begin
         t1 = m[7] + (rr(m[4], 6) ^ rr(m[4], 11) ^ rr(m[4], 25))
            + ((m[4] & m[5]) ^ (~m[4] & m[6])) + bus.k + bus.w;
         t2 = (rr(m[0], 2) ^ rr(m[0], 13) ^ rr(m[0], 22))
            + ((m[0] & m[1]) ^ (m[0] & m[2]) ^ (m[1] & m[2]));
         for (int i = 7; i > 0; i--) m[i] = m[i-1];
         m[4] = m[4] + t1;
         m[0] = t1 + t2;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_reg(i) !== m[i]) begin
               errors++;
               $display("FAIL cycle_reg%0d t=%0t got %08h exp %08h", i, $time, dut_reg(i), m[i]);
            end
         end
      end
   end

   task automatic cyc(input logic r, input logic i, input logic e,
                      input logic [31:0] wv, input logic [31:0] kv);
      rst = r; bus.init = i; bus.en = e; bus.w = wv; bus.k = kv;
      @(negedge clk);
   endtask

   task automatic lit(input string name, input logic [31:0] exp [8]);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (dut_reg(i) !== exp[i]) begin
            errors++;
            $display("FAIL %s_dut_reg%0d got %08h exp %08h", name, i, dut_reg(i), exp[i]);
         end
         checks++;
         if (m[i] !== exp[i]) begin
            errors++;
            $display("FAIL %s_model_reg%0d got %08h exp %08h", name, i, m[i], exp[i]);
         end
      end
   endtask

   task automatic rounds(input int from, input int to);
      for (int t = from; t <= to; t++) cyc(1'b0, 1'b0, 1'b1, ws[t], kt[t]);
   endtask

   logic [31:0] zeros [8] = '{default: 32'h0};
   logic [31:0] r0    [8] = '{32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                              32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab};
   logic [31:0] r1    [8] = '{32'h5a6ad9ad, 32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85,
                              32'h78ce7989, 32'hfa2a4622, 32'h510e527f, 32'h9b05688c};
   logic [31:0] r63   [8] = '{32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
                              32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894};

   initial begin
      logic [31:0] s0, s1, sum;
      checks = 0; errors = 0; chk_en = 1'b0;
      iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
      kt = '{
         32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
         32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
         32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
         32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
         32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
         32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
         32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
         32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

      // "abc" padded block and its expanded schedule
      for (int t = 0; t < 16; t++) ws[t] = 32'h0;
      ws[0]  = 32'h61626380;
      ws[15] = 32'h00000018;
      for (int t = 16; t < 64; t++) begin
         s0 = rr(ws[t-15], 7) ^ rr(ws[t-15], 18) ^ (ws[t-15] >> 3);
         s1 = rr(ws[t-2], 17) ^ rr(ws[t-2], 19) ^ (ws[t-2] >> 10);
         ws[t] = s1 + ws[t-7] + s0 + ws[t-16];
      end

      bus.hash0 = iv[0]; bus.hash1 = iv[1]; bus.hash2 = iv[2]; bus.hash3 = iv[3];
      bus.hash4 = iv[4]; bus.hash5 = iv[5]; bus.hash6 = iv[6]; bus.hash7 = iv[7];
      rst = 1'b1; bus.init = 1'b0; bus.en = 1'b0; bus.w = 32'h0; bus.k = 32'h0;
      @(negedge clk);
      chk_en = 1'b1;
      lit("reset", zeros);

      cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      lit("init", iv);
      rounds(0, 0);
      lit("round0", r0);
      rounds(1, 1);
      lit("round1", r1);
      rounds(2, 20);

      // stall: w/k change but nothing may move
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, $urandom, $urandom);
      rounds(21, 63);
      lit("round63", r63);
      sum = bus.A + iv[0];
      checks++;
      if (sum !== 32'hba7816bf) begin
         errors++;
         $display("FAIL digest_word0 got %08h exp ba7816bf", sum);
      end

      // init beats en, even with junk w/k present
      cyc(1'b0, 1'b1, 1'b1, 32'hdeadbeef, 32'hcafef00d);
      lit("init_over_en", iv);
      rounds(0, 5);
      // init mid-block abandons state
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      lit("reinit", iv);
      rounds(0, 0);
      lit("reinit_round0", r0);
      // rst beats init and en
      cyc(1'b1, 1'b1, 1'b1, 32'h12345678, 32'h9abcdef0);
      lit("rst_over_init", zeros);
      cyc(1'b0, 1'b0, 1'b1, 32'h11111111, 32'h22222222);
      cyc(1'b1, 1'b0, 1'b1, 32'h33333333, 32'h44444444);
      lit("rst_over_en", zeros);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      rounds(0, 1);
      lit("after_rst_round1", r1);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
